// File: rtl/cfg_dprio_avmm_gate.sv
// cfg_dprio_avmm_gate
// Avalon-MM gate that sits after the DPRIO-disable control stage. Forwards
// reads/writes to the DPRIO register file while dprio_dis is low, rejects
// them locally with an error response while it is high, bounds register-file
// read latency with a timeout, and keeps a saturating error count.
//
// Handshake: a command is accepted in a cycle where (avmm_read | avmm_write)
// is high and avmm_waitrequest is low; waitrequest is low only in IDLE, so
// at most one access is ever in flight. avmm_readdatavalid is a one-cycle
// strobe per accepted read; avmm_resp_err qualifies that strobe, or on its
// own (readdatavalid low) marks a rejected write.
module cfg_dprio_avmm_gate #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dprio_dis,
    input  logic                  avmm_read,
    input  logic                  avmm_write,
    input  logic [ADDR_WIDTH-1:0] avmm_addr,
    input  logic [DATA_WIDTH-1:0] avmm_wdata,
    output logic                  avmm_waitrequest,
    output logic [DATA_WIDTH-1:0] avmm_readdata,
    output logic                  avmm_readdatavalid,
    output logic                  avmm_resp_err,
    output logic                  reg_read,
    output logic                  reg_write,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_rdata_valid,
    output logic [7:0]            err_cnt,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WR      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t                r_state;
    logic                  r_rd_dis_pend;   // RESP entered from a rejected read: response still owed
    logic [7:0]            r_cnt;           // cycles spent in RD_WAIT
    logic [7:0]            r_err_cnt;
    logic                  r_reg_read;
    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [DATA_WIDTH-1:0] r_reg_wdata;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_rdv;
    logic                  r_err;
    logic [7:0]            w_err_cnt_inc;

    // Saturating increment of the error count
    assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    // Stall everywhere except IDLE; reset forces INIT so this is high during reset
    assign avmm_waitrequest   = (r_state != S_IDLE);
    assign avmm_readdata      = r_readdata;
    assign avmm_readdatavalid = r_rdv;
    assign avmm_resp_err      = r_err;
    assign reg_read           = r_reg_read;
    assign reg_write          = r_reg_write;
    assign reg_addr           = r_reg_addr;
    assign reg_wdata          = r_reg_wdata;
    assign err_cnt            = r_err_cnt;
    assign o_dbg_state        = r_state;

    // Access FSM with registered strobes, data and error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_INIT;
            r_rd_dis_pend <= 1'b0;
            r_cnt         <= 8'd0;
            r_err_cnt     <= 8'd0;
            r_reg_read    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_wdata   <= '0;
            r_readdata    <= '0;
            r_rdv         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_reg_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_rdv       <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_state <= S_IDLE;
                end
                S_IDLE: begin
                    // Read has priority; a simultaneous write is dropped silently
                    if (avmm_read) begin
                        if (dprio_dis) begin
                            r_rd_dis_pend <= 1'b1;
                            r_state       <= S_RESP;
                        end else begin
                            r_reg_addr <= avmm_addr;
                            r_reg_read <= 1'b1;
                            r_cnt      <= 8'd0;
                            r_state    <= S_RD_WAIT;
                        end
                    end else if (avmm_write) begin
                        if (dprio_dis) begin
                            r_err         <= 1'b1;
                            r_err_cnt     <= w_err_cnt_inc;
                            r_rd_dis_pend <= 1'b0;
                            r_state       <= S_RESP;
                        end else begin
                            r_reg_addr  <= avmm_addr;
                            r_reg_wdata <= avmm_wdata;
                            r_reg_write <= 1'b1;
                            r_state     <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    r_state <= S_IDLE;
                end
                S_RD_WAIT: begin
                    if (reg_rdata_valid) begin
                        r_readdata <= reg_rdata;
                        r_rdv      <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (r_cnt == LP_TIMEOUT) begin
                        // Waited the full window with no data: answer with an error
                        r_readdata <= '0;
                        r_rdv      <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_cnt  <= w_err_cnt_inc;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (r_rd_dis_pend) begin
                        // Rejected read: issue its error response one cycle after entry
                        r_rd_dis_pend <= 1'b0;
                        r_readdata    <= '0;
                        r_rdv         <= 1'b1;
                        r_err         <= 1'b1;
                        r_err_cnt     <= w_err_cnt_inc;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_dprio_avmm_gate.sv
// Testbench for cfg_dprio_avmm_gate: directed accesses, a register-file
// model with programmable latency, and a scoreboard of timed events.
module tb_cfg_dprio_avmm_gate;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int EW = 16 + 3 + 1 + AW + DW;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RDW  = 3'd3;

  localparam logic [2:0] K_WR  = 3'd1;
  localparam logic [2:0] K_RD  = 3'd2;
  localparam logic [2:0] K_RSP = 3'd3;
  localparam logic [2:0] K_REJ = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          dprio_dis = 1'b0;
  logic          avmm_read = 1'b0;
  logic          avmm_write = 1'b0;
  logic [AW-1:0] avmm_addr = '0;
  logic [DW-1:0] avmm_wdata = '0;
  logic          avmm_waitrequest;
  logic [DW-1:0] avmm_readdata;
  logic          avmm_readdatavalid;
  logic          avmm_resp_err;
  logic          reg_read;
  logic          reg_write;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          reg_rdata_valid;
  logic [7:0]    err_cnt;
  logic [2:0]    dbg_state;

  cfg_dprio_avmm_gate #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dprio_dis(dprio_dis),
    .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_addr(avmm_addr), .avmm_wdata(avmm_wdata),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .avmm_resp_err(avmm_resp_err),
    .reg_read(reg_read), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rdata_valid(reg_rdata_valid),
    .err_cnt(err_cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Event word: {cycle, kind, err, addr, data}
  function automatic logic [EW-1:0] ev(input int c, input logic [2:0] kind, input logic err,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {16'(c), kind, err, a, d};
  endfunction

  task automatic mon_event(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got 0x%0h, expected no event (cycle %0d)", got, cyc);
    end else begin
      e = exp_q.pop_front();
      check("sb_event", got, e);
    end
  endtask

  // Monitor: sample outputs on the falling edge, compare against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_write) mon_event(ev(cyc, K_WR, 1'b0, reg_addr, reg_wdata));
        if (reg_read) mon_event(ev(cyc, K_RD, 1'b0, reg_addr, '0));
        if (avmm_readdatavalid) mon_event(ev(cyc, K_RSP, avmm_resp_err, '0, avmm_readdata));
        else if (avmm_resp_err) mon_event(ev(cyc, K_REJ, 1'b1, '0, '0));
      end
    end
  end

  // ---------------- register-file model ----------------
  int            rf_k = 0;        // 0 = never respond
  logic [DW-1:0] rf_data = '0;
  int            stray_cyc = -1;

  initial begin
    int pend_cyc;
    pend_cyc = -1;
    reg_rdata_valid = 1'b0;
    reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && reg_read && rf_k > 0) pend_cyc = cyc + rf_k;
      @(posedge clk);
      #1;
      reg_rdata_valid = 1'b0;
      if (cyc == pend_cyc) begin
        reg_rdata_valid = 1'b1;
        reg_rdata = rf_data;
      end else if (cyc == stray_cyc) begin
        reg_rdata_valid = 1'b1;
        reg_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after acceptance cycle n
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int n);
    avmm_read = rd;
    avmm_write = wr;
    avmm_addr = a;
    avmm_wdata = d;
    n = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!avmm_waitrequest) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) begin
      n_checks++;
      $display("FAIL accept_timeout: waitrequest=1 for 400 cycles, expected 0");
    end
    @(posedge clk);
    #1;
    avmm_read = 1'b0;
    avmm_write = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!avmm_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL idle_timeout: waitrequest=1 for 400 cycles, expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dis,
                          output int n);
    dprio_dis = dis;
    issue(1'b0, 1'b1, a, d, n);
    if (!dis) exp_q.push_back(ev(n + 1, K_WR, 1'b0, a, d));
    else exp_q.push_back(ev(n + 1, K_REJ, 1'b1, '0, '0));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic dis, input int k,
                         input logic [DW-1:0] d, input bit resp, output int n);
    rf_k = k;
    rf_data = d;
    dprio_dis = dis;
    issue(1'b1, 1'b0, a, '0, n);
    if (dis) begin
      exp_q.push_back(ev(n + 2, K_RSP, 1'b1, '0, '0));
    end else begin
      exp_q.push_back(ev(n + 1, K_RD, 1'b0, a, '0));
      if (resp) begin
        if (k >= 1 && k <= TO) exp_q.push_back(ev(n + 2 + k, K_RSP, 1'b0, '0, d));
        else exp_q.push_back(ev(n + 2 + TO, K_RSP, 1'b1, '0, '0));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, n1, n2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitrequest", avmm_waitrequest, 1'b1);
    check("rst_state", dbg_state, ST_INIT);
    check("rst_strobes", {avmm_readdatavalid, avmm_resp_err, reg_read, reg_write}, 4'b0000);
    check("rst_regs", {reg_addr, reg_wdata, avmm_readdata, err_cnt}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_waitrequest", avmm_waitrequest, 1'b1);
    @(negedge clk);
    check("post_init_waitrequest", avmm_waitrequest, 1'b0);
    check("post_init_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;

    // Enabled write
    do_write(10'h012, 32'hDEADBEEF, 1'b0, n);
    @(negedge clk);
    check("wr_waitreq_n1", avmm_waitrequest, 1'b1);
    check("wr_state_n1", dbg_state, ST_WR);
    @(negedge clk);
    check("wr_waitreq_n2", avmm_waitrequest, 1'b0);
    check("wr_err_cnt", err_cnt, 8'd0);
    @(posedge clk);
    #1;

    // Back-to-back writes every 2 cycles
    do_write(10'h155, 32'h12345678, 1'b0, n1);
    do_write(10'h2AA, 32'hA5A5A5A5, 1'b0, n2);
    check("wr_throughput", n2 - n1, 2);
    wait_idle();

    // Enabled read, k=3
    do_read(10'h3FF, 1'b0, 3, 32'h00C0FFEE, 1'b1, n);
    wait_idle();
    check("rd_data_hold", avmm_readdata, 32'h00C0FFEE);

    // Read and write together: read served, write dropped
    rf_k = 1;
    rf_data = 32'h0BADCAFE;
    dprio_dis = 1'b0;
    issue(1'b1, 1'b1, 10'h077, 32'hFFFFFFFF, n);
    exp_q.push_back(ev(n + 1, K_RD, 1'b0, 10'h077, '0));
    exp_q.push_back(ev(n + 3, K_RSP, 1'b0, '0, 32'h0BADCAFE));
    wait_idle();

    // Disabled write then read
    do_write(10'h044, 32'h11111111, 1'b1, n);
    do_read(10'h055, 1'b1, 0, '0, 1'b1, n);
    wait_idle();
    check("dis_err_cnt", err_cnt, 8'd2);
    check("dis_rdata_zero", avmm_readdata, 32'h0);

    // Timeout with a late stray valid
    do_read(10'h100, 1'b0, 0, '0, 1'b1, n);
    stray_cyc = n + 8;
    repeat (10) @(posedge clk);
    #1;
    check("to_err_cnt", err_cnt, 8'd3);
    check("to_rdata_zero", avmm_readdata, 32'h0);
    check("to_state_idle", dbg_state, ST_IDLE);

    // Valid exactly at k = TIMEOUT
    do_read(10'h101, 1'b0, TO, 32'hCAFEF00D, 1'b1, n);
    wait_idle();
    check("k_eq_to_err_cnt", err_cnt, 8'd3);

    // dprio_dis rises during an in-flight enabled read
    do_read(10'h0AB, 1'b0, 3, 32'h5EEDF00D, 1'b1, n);
    @(posedge clk);
    #1;
    dprio_dis = 1'b1;
    wait_idle();
    check("inflight_err_cnt", err_cnt, 8'd3);
    check("inflight_rdata", avmm_readdata, 32'h5EEDF00D);

    // Saturation: 300 disabled reads
    for (int i = 0; i < 251; i++) do_read(10'(i), 1'b1, 0, '0, 1'b1, n);
    wait_idle();
    check("sat_err_cnt_254", err_cnt, 8'd254);
    for (int i = 251; i < 300; i++) do_read(10'(i), 1'b1, 0, '0, 1'b1, n);
    wait_idle();
    check("sat_err_cnt_255", err_cnt, 8'd255);

    // Reset in the middle of a read
    do_read(10'h222, 1'b0, 0, '0, 1'b0, n);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rd_state", dbg_state, ST_RDW);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_waitrequest", avmm_waitrequest, 1'b1);
    check("mid_rst_state", dbg_state, ST_INIT);
    check("mid_rst_strobes", {avmm_readdatavalid, avmm_resp_err, reg_read, reg_write}, 4'b0000);
    check("mid_rst_regs", {reg_addr, reg_wdata, avmm_readdata, err_cnt}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_init", dbg_state, ST_INIT);
    @(negedge clk);
    check("mid_rel_idle", avmm_waitrequest, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("sb_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Run-time guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
